// File: rtl/console_pkg.sv
// Shared constants and state encoding for the console arbiter.
package console_pkg;

   localparam int unsigned CONSOLE_DW = 7;
   localparam logic [CONSOLE_DW-1:0] CONSOLE_LF = 7'h0a;

   typedef enum logic {
      IDLE   = 1'b0,
      LOCKED = 1'b1
   } state_e;

endpackage

// File: rtl/console_rr_pick.sv
// Combinational round-robin picker: first set request above last_i, wrapping.
module console_rr_pick
   import console_pkg::*;
#(
   parameter int unsigned NIN = 2,
   localparam int unsigned IW = (NIN > 1) ? $clog2(NIN) : 1
) (
   input  logic [NIN-1:0] req_i,
   input  logic [IW-1:0]  last_i,
   output logic [NIN-1:0] grant_o,
   output logic [IW-1:0]  idx_o,
   output logic           valid_o
);

   // Scan last_i+1 .. last_i+NIN (mod NIN); the first hit wins.
   always_comb begin
      int unsigned sum;
      logic [IW-1:0] k;
      grant_o = '0;
      idx_o   = '0;
      valid_o = 1'b0;
      for (int unsigned i = 1; i <= NIN; i++) begin
         sum = 32'(last_i) + i;
         if (sum >= NIN) begin
            sum = sum - NIN;
         end
         k = IW'(sum);
         if (!valid_o && req_i[k]) begin
            valid_o    = 1'b1;
            grant_o[k] = 1'b1;
            idx_o      = k;
         end
      end
   end

endmodule

// File: rtl/console_arbiter.sv
// Line-granular arbiter sharing one 7-bit console stream between NIN sources.
module console_arbiter
   import console_pkg::*;
#(
   parameter int unsigned NIN     = 2,
   parameter int unsigned TIMEOUT = 1024,
   parameter int unsigned LGTO    = 11
) (
   input  logic                      i_clk,
   input  logic                      i_reset_n,
   input  logic [NIN-1:0]            i_req_stb,
   input  logic [CONSOLE_DW*NIN-1:0] i_req_data,
   output logic [NIN-1:0]            o_req_busy,
   output logic                      o_console_stb,
   output logic [CONSOLE_DW-1:0]     o_console_data,
   input  logic                      i_console_busy,
   output logic [NIN-1:0]            o_grant,
   output logic                      o_active
);

   localparam int unsigned IW = (NIN > 1) ? $clog2(NIN) : 1;

   state_e                state_q;
   logic [IW-1:0]         g_q;
   logic [IW-1:0]         last_q;
   logic [NIN-1:0]        grant_q;
   logic [LGTO-1:0]       cnt_q, cnt_d;
   logic                  stb_q, stb_d;
   logic [CONSOLE_DW-1:0] data_q, data_d;

   logic                  locked;
   logic                  out_free;
   logic                  g_stb;
   logic [CONSOLE_DW-1:0] g_data;
   logic                  load;
   logic [LGTO-1:0]       cnt_inc;
   logic                  timed_out;
   logic                  rel;

   logic [NIN-1:0]        pick_grant;
   logic [IW-1:0]         pick_idx;
   logic                  pick_valid;

   console_rr_pick #(
      .NIN (NIN)
   ) u_pick (
      .req_i   (i_req_stb),
      .last_i  (last_q),
      .grant_o (pick_grant),
      .idx_o   (pick_idx),
      .valid_o (pick_valid)
   );

   // Granted-source view, load condition and release decision.
   always_comb begin
      locked    = (state_q == LOCKED);
      out_free  = !stb_q || !i_console_busy;
      g_stb     = i_req_stb[g_q];
      g_data    = i_req_data[32'(g_q)*CONSOLE_DW +: CONSOLE_DW];
      load      = locked && g_stb && out_free;
      cnt_inc   = cnt_q + LGTO'(1);
      timed_out = (TIMEOUT != 0) && locked && !g_stb && (cnt_inc == LGTO'(TIMEOUT));
      // LF load and timeout together still make a single release.
      rel       = locked && ((load && (g_data == CONSOLE_LF)) || timed_out);
   end

   // Next-state for the output register and the idle-timeout counter.
   always_comb begin
      stb_d  = stb_q;
      data_d = data_q;
      if (load) begin
         stb_d  = 1'b1;
         data_d = g_data;
      end else if (!i_console_busy) begin
         stb_d = 1'b0;
      end

      cnt_d = '0;
      if (locked && !rel && !g_stb && (TIMEOUT != 0)) begin
         cnt_d = cnt_inc;
      end
   end

   // Busy is combinational from downstream busy: there is no skid buffer.
   always_comb begin
      o_req_busy = '1;
      for (int k = 0; k < NIN; k++) begin
         if (locked && (g_q == IW'(k)) && out_free) begin
            o_req_busy[k] = 1'b0;
         end
      end
   end

   // Arbitration FSM with registered grant, counter and output stage.
   always_ff @(posedge i_clk) begin
      if (!i_reset_n) begin
         state_q <= IDLE;
         g_q     <= '0;
         last_q  <= IW'(NIN - 1);
         grant_q <= '0;
         cnt_q   <= '0;
         stb_q   <= 1'b0;
         data_q  <= '0;
      end else begin
         stb_q  <= stb_d;
         data_q <= data_d;
         cnt_q  <= cnt_d;
         case (state_q)
            IDLE: begin
               if (pick_valid) begin
                  g_q     <= pick_idx;
                  grant_q <= pick_grant;
                  state_q <= LOCKED;
               end
            end
            LOCKED: begin
               if (rel) begin
                  last_q  <= g_q;
                  grant_q <= '0;
                  state_q <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign o_grant        = grant_q;
   assign o_active       = (state_q == LOCKED);
   assign o_console_stb  = stb_q;
   assign o_console_data = data_q;

endmodule
